// File: rtl/pri_decoder_seq_pkg.sv
// Shared definitions for the 15-line priority codec (encoder and decoder side).
// Holds the default line count and code width, the sequencer state encodings
// and a small helper used to size the hold/gap counter.
package pri_decoder_seq_pkg;

  localparam int DEF_WIDTH  = 15;
  localparam int DEF_CODE_W = 4;

  // Sequencer states, kept as plain 2-bit constants so the encoding matches
  // the legacy codec files.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pri_decoder_seq_onehot_dec.sv
// Combinational binary-to-one-hot decoder.
// Ports:
//   code      in   CODE_W  binary code
//   onehot    out  WIDTH   1<<code, all-zero when code is out of range
//   in_range  out  1       code < WIDTH
// Also used standalone to cross-check the LSB-priority encoder.
module pri_decoder_seq_onehot_dec
  import pri_decoder_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic [CODE_W-1:0] code,
  output logic [WIDTH-1:0]  onehot,
  output logic              in_range
);

  logic [31:0] code_ext;

  assign code_ext = {{(32 - CODE_W){1'b0}}, code};
  assign in_range = (code_ext < 32'(WIDTH));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = (code_ext == 32'(i));
    end
  end

endmodule

// File: rtl/pri_decoder_seq.sv
// Sequenced binary-to-one-hot decoder feeding the strobe/LED bank.
// Each accepted code is shown as 1<<code for HOLD cycles followed by GAP
// all-zero cycles. A one-entry pending buffer takes the next code while the
// current one is being driven.
// Ports:
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       in_code is valid
//   in_ready    out  1       a code can be accepted (pending buffer empty)
//   in_code     in   CODE_W  binary code to decode
//   out_onehot  out  WIDTH   registered one-hot word, zero when not driving
//   out_valid   out  1       high while out_onehot is driven
//   err_code    out  1       one-cycle pulse after accepting a code >= WIDTH
module pri_decoder_seq
  import pri_decoder_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CODE_W = DEF_CODE_W,
  parameter int HOLD   = 4,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [WIDTH-1:0]  out_onehot,
  output logic              out_valid,
  output logic              err_code
);

  localparam int CNT_W = $clog2(max3(HOLD, GAP, 2));
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_full_q, pend_full_d;
  logic [CODE_W-1:0] pend_code_q, pend_code_d;
  logic [WIDTH-1:0]  onehot_q, onehot_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;

  logic              accept;
  logic              acc_ok;
  logic              load_pt;
  logic [CODE_W-1:0] dec_code;
  logic [WIDTH-1:0]  dec_onehot;
  logic              dec_in_range;

  assign in_ready = ~pend_full_q;
  assign accept   = in_valid & in_ready;

  // A full pending buffer blocks new accepts, so one decoder serves both the
  // bypass path and the pending path: while pend_full_q is set in_code is
  // irrelevant, and while it is clear the pending code is unused.
  assign dec_code = pend_full_q ? pend_code_q : in_code;

  pri_decoder_seq_onehot_dec #(
    .WIDTH  (WIDTH),
    .CODE_W (CODE_W)
  ) u_dec (
    .code     (dec_code),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  // Out-of-range codes complete the handshake but are dropped here.
  assign acc_ok = accept & dec_in_range;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_code_d = pend_code_q;
    onehot_d    = onehot_q;
    out_valid_d = out_valid_q;
    err_d       = accept & ~dec_in_range;
    load_pt     = 1'b0;

    case (state_q)
      ST_IDLE: load_pt = 1'b1;
      ST_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (GAP > 0) begin
          state_d     = ST_GAP;
          onehot_d    = '0;
          out_valid_d = 1'b0;
          cnt_d       = GAP_M1;
        end else begin
          load_pt = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          load_pt = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        onehot_d    = '0;
        out_valid_d = 1'b0;
      end
    endcase

    if (load_pt) begin
      // Pending code has priority; otherwise a fresh accept bypasses the buffer.
      if (pend_full_q || acc_ok) begin
        state_d     = ST_DRIVE;
        onehot_d    = dec_onehot;
        out_valid_d = 1'b1;
        cnt_d       = HOLD_M1;
        pend_full_d = 1'b0;
      end else begin
        state_d     = ST_IDLE;
        onehot_d    = '0;
        out_valid_d = 1'b0;
        cnt_d       = '0;
      end
    end else if (acc_ok) begin
      pend_full_d = 1'b1;
      pend_code_d = in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      onehot_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      onehot_q    <= onehot_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // The pending code is qualified by pend_full_q and needs no reset.
  always_ff @(posedge clk) begin
    pend_code_q <= pend_code_d;
  end

  assign out_onehot = onehot_q;
  assign out_valid  = out_valid_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_pri_decoder_seq.sv
module tb_pri_decoder_seq;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid;
  logic        a_in_ready;
  logic [3:0]  a_in_code;
  logic [14:0] a_out_onehot;
  logic        a_out_valid;
  logic        a_err_code;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [3:0]  b_in_code;
  logic [14:0] b_out_onehot;
  logic        b_out_valid;
  logic        b_err_code;

  int n_cmp;
  int n_err;

  pri_decoder_seq #(
    .WIDTH (15), .CODE_W (4), .HOLD (4), .GAP (1)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_code    (a_in_code),
    .out_onehot (a_out_onehot),
    .out_valid  (a_out_valid),
    .err_code   (a_err_code)
  );

  pri_decoder_seq #(
    .WIDTH (15), .CODE_W (4), .HOLD (1), .GAP (0)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_code    (b_in_code),
    .out_onehot (b_out_onehot),
    .out_valid  (b_out_valid),
    .err_code   (b_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_a(input string tag, input logic [14:0] oh, input logic ov, input logic rdy);
    chk({tag, ".onehot"}, 32'(a_out_onehot), 32'(oh));
    chk({tag, ".valid"},  32'(a_out_valid),  32'(ov));
    chk({tag, ".ready"},  32'(a_in_ready),   32'(rdy));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_code = 4'h0;
    b_in_valid = 1'b0; b_in_code = 4'h0;
    step(2);

    // Reset state
    chk_a("rst_a", 15'h0000, 1'b0, 1'b1);
    chk("rst_a.err", 32'(a_err_code), 32'd0);
    chk("rst_b.onehot", 32'(b_out_onehot), 32'd0);
    chk("rst_b.ready", 32'(b_in_ready), 32'd1);
    rst_n = 1'b1;
    step(1);
    chk_a("post_rst_a", 15'h0000, 1'b0, 1'b1);

    // Single code 3: four cycles of 0x0008, one zero cycle, then idle
    a_in_valid = 1'b1; a_in_code = 4'h3;
    step(1);
    a_in_valid = 1'b0;
    chk_a("single.e1", 15'h0008, 1'b1, 1'b1);
    step(1); chk_a("single.e2", 15'h0008, 1'b1, 1'b1);
    step(1); chk_a("single.e3", 15'h0008, 1'b1, 1'b1);
    step(1); chk_a("single.e4", 15'h0008, 1'b1, 1'b1);
    step(1); chk_a("single.gap", 15'h0000, 1'b0, 1'b1);
    step(1); chk_a("single.idle", 15'h0000, 1'b0, 1'b1);

    // Back-to-back: 0 then E one cycle later
    a_in_valid = 1'b1; a_in_code = 4'h0;
    step(1);
    chk_a("b2b.e1", 15'h0001, 1'b1, 1'b1);
    a_in_code = 4'hE;
    step(1);
    a_in_valid = 1'b0;
    chk_a("b2b.e2", 15'h0001, 1'b1, 1'b0);
    step(2); chk_a("b2b.e4", 15'h0001, 1'b1, 1'b0);
    step(1); chk_a("b2b.gap", 15'h0000, 1'b0, 1'b0);
    step(1); chk_a("b2b.e6", 15'h4000, 1'b1, 1'b1);
    step(3); chk_a("b2b.e9", 15'h4000, 1'b1, 1'b1);
    step(1); chk_a("b2b.gap2", 15'h0000, 1'b0, 1'b1);
    step(1); chk_a("b2b.idle", 15'h0000, 1'b0, 1'b1);

    // Invalid code while idle
    a_in_valid = 1'b1; a_in_code = 4'hF;
    step(1);
    a_in_valid = 1'b0;
    chk("inv_idle.err", 32'(a_err_code), 32'd1);
    chk_a("inv_idle", 15'h0000, 1'b0, 1'b1);
    step(1);
    chk("inv_idle.err_clr", 32'(a_err_code), 32'd0);
    chk_a("inv_idle.after", 15'h0000, 1'b0, 1'b1);

    // Invalid code during DRIVE: pulse, no pending entry
    a_in_valid = 1'b1; a_in_code = 4'h5;
    step(1);
    chk_a("inv_drv.e1", 15'h0020, 1'b1, 1'b1);
    a_in_code = 4'hF;
    step(1);
    a_in_valid = 1'b0;
    chk("inv_drv.err", 32'(a_err_code), 32'd1);
    chk_a("inv_drv.e2", 15'h0020, 1'b1, 1'b1);
    step(1);
    chk("inv_drv.err_clr", 32'(a_err_code), 32'd0);
    step(2); chk_a("inv_drv.gap", 15'h0000, 1'b0, 1'b1);
    step(1); chk_a("inv_drv.idle", 15'h0000, 1'b0, 1'b1);
    step(1); chk_a("inv_drv.idle2", 15'h0000, 1'b0, 1'b1);

    // Stall: 1 driving, 7 pending, 9 held on the input until accepted once
    a_in_valid = 1'b1; a_in_code = 4'h1;
    step(1);
    chk_a("stall.e1", 15'h0002, 1'b1, 1'b1);
    a_in_code = 4'h7;
    step(1);
    a_in_code = 4'h9;
    chk_a("stall.e2", 15'h0002, 1'b1, 1'b0);
    step(1); chk_a("stall.e3", 15'h0002, 1'b1, 1'b0);
    step(2); chk_a("stall.gap", 15'h0000, 1'b0, 1'b0);
    step(1); chk_a("stall.e6", 15'h0080, 1'b1, 1'b1);
    step(1);
    a_in_valid = 1'b0;
    chk_a("stall.e7", 15'h0080, 1'b1, 1'b0);
    step(2); chk_a("stall.e9", 15'h0080, 1'b1, 1'b0);
    step(1); chk_a("stall.gap2", 15'h0000, 1'b0, 1'b0);
    step(1); chk_a("stall.e11", 15'h0200, 1'b1, 1'b1);
    step(3); chk_a("stall.e14", 15'h0200, 1'b1, 1'b1);
    step(1); chk_a("stall.gap3", 15'h0000, 1'b0, 1'b1);
    step(1); chk_a("stall.idle", 15'h0000, 1'b0, 1'b1);
    step(1); chk_a("stall.idle2", 15'h0000, 1'b0, 1'b1);

    // GAP=0, HOLD=1 build: codes 1,2,3 on consecutive cycles
    b_in_valid = 1'b1; b_in_code = 4'h1;
    step(1);
    chk("g0.w1", 32'(b_out_onehot), 32'h0002);
    chk("g0.w1.valid", 32'(b_out_valid), 32'd1);
    b_in_code = 4'h2;
    step(1);
    chk("g0.w2", 32'(b_out_onehot), 32'h0004);
    chk("g0.w2.ready", 32'(b_in_ready), 32'd1);
    b_in_code = 4'h3;
    step(1);
    b_in_valid = 1'b0;
    chk("g0.w3", 32'(b_out_onehot), 32'h0008);
    step(1);
    chk("g0.idle", 32'(b_out_onehot), 32'h0000);
    chk("g0.idle.valid", 32'(b_out_valid), 32'd0);

    // Mid-DRIVE reset with a pending code
    a_in_valid = 1'b1; a_in_code = 4'h2;
    step(1);
    a_in_code = 4'h4;
    step(1);
    a_in_valid = 1'b0;
    chk_a("mrst.pre", 15'h0004, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_a("mrst.async", 15'h0000, 1'b0, 1'b1);
    step(1);
    rst_n = 1'b1;
    step(1); chk_a("mrst.rel1", 15'h0000, 1'b0, 1'b1);
    chk("mrst.err", 32'(a_err_code), 32'd0);
    step(4); chk_a("mrst.rel5", 15'h0000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
